// File: rtl/ap_perf_pkg.sv
// Shared types and sizing for the ap_ctrl_hs performance sampler.
package ap_perf_pkg;

  localparam int unsigned TXN_ID_W   = 16;
  localparam int unsigned DROP_W     = 16;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned ITER_W_DEF = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t RUN     = 2'd1;
  localparam state_t STOPPED = 2'd2;

  // Record layout at the default counter widths, MSB first.
  typedef struct packed {
    logic                  truncated;
    logic [TXN_ID_W-1:0]   txn_id;
    logic [CNT_W_DEF-1:0]  start_time;
    logic [CNT_W_DEF-1:0]  latency;
    logic [CNT_W_DEF-1:0]  interval;
    logic [ITER_W_DEF-1:0] iter_count;
    logic [CNT_W_DEF-1:0]  stall_count;
  } perf_rec_t;

  function automatic int unsigned rec_width(int unsigned cnt_w, int unsigned iter_w);
    return 1 + TXN_ID_W + 4 * cnt_w + iter_w;
  endfunction

endpackage

// File: rtl/ap_ctrl_perf_sampler_if.sv
// Valid/ready record stream between the sampler and its consumer.
interface ap_ctrl_perf_sampler_if
  import ap_perf_pkg::*;
#(
  parameter int unsigned REC_W = rec_width(CNT_W_DEF, ITER_W_DEF)
) ();

  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);

endinterface

// File: rtl/perf_rec_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always on pop_data.
module perf_rec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W + 1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ap_ctrl_perf_sampler.sv
// Times one ap_ctrl_hs transaction at a time and emits one performance record per
// transaction through a small FWFT FIFO.
module ap_ctrl_perf_sampler
  import ap_perf_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ITER_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ap_start,
  input  logic                   ap_done,
  input  logic                   iter_fire,
  input  logic                   iter_stall,
  input  logic                   finish,
  ap_ctrl_perf_sampler_if.master rec,
  output logic                   busy,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   drained
);

  localparam int unsigned REC_W = rec_width(CNT_W, ITER_W);

  typedef struct packed {
    logic                truncated;
    logic [TXN_ID_W-1:0] txn_id;
    logic [CNT_W-1:0]    start_time;
    logic [CNT_W-1:0]    latency;
    logic [CNT_W-1:0]    interval;
    logic [ITER_W-1:0]   iter_count;
    logic [CNT_W-1:0]    stall_count;
  } rec_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cycle_q;
  logic [CNT_W-1:0]    start_q, start_d, prev_q, prev_d, ivl_q, ivl_d;
  logic [CNT_W-1:0]    lat_q, lat_d, stall_q, stall_d, lat_inc, stall_inc;
  logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
  logic                have_prev_q, have_prev_d;
  logic [TXN_ID_W-1:0] txn_q;
  logic [DROP_W-1:0]   drop_q;
  logic                drained_q;
  logic                push, drop, fifo_full, fifo_empty;
  rec_t                rec_d;

  // Saturating run counters, including this cycle's qualifiers.
  always_comb begin
    lat_inc   = (lat_q == '1) ? lat_q : lat_q + CNT_W'(1);
    iter_inc  = (iter_fire && iter_q != '1) ? iter_q + ITER_W'(1) : iter_q;
    stall_inc = (iter_stall && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    ivl_d       = ivl_q;
    lat_d       = lat_q;
    iter_d      = iter_q;
    stall_d     = stall_q;
    push        = 1'b0;
    rec_d       = '0;
    case (state_q)
      IDLE: begin
        if (finish) begin
          state_d = STOPPED;
        end else if (ap_start) begin
          start_d     = cycle_q;
          prev_d      = cycle_q;
          have_prev_d = 1'b1;
          ivl_d       = have_prev_q ? cycle_q - prev_q : '0;
          lat_d       = '0;
          iter_d      = ITER_W'(iter_fire);
          stall_d     = CNT_W'(iter_stall);
          if (ap_done) begin
            push              = 1'b1;
            rec_d.txn_id      = txn_q;
            rec_d.start_time  = cycle_q;
            rec_d.interval    = ivl_d;
            rec_d.iter_count  = iter_d;
            rec_d.stall_count = stall_d;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        lat_d   = lat_inc;
        iter_d  = iter_inc;
        stall_d = stall_inc;
        if (ap_done || finish) begin
          push              = 1'b1;
          rec_d.truncated   = ~ap_done;
          rec_d.txn_id      = txn_q;
          rec_d.start_time  = start_q;
          rec_d.latency     = lat_inc;
          rec_d.interval    = ivl_q;
          rec_d.iter_count  = iter_inc;
          rec_d.stall_count = stall_inc;
          state_d           = finish ? STOPPED : IDLE;
        end
      end
      default: ;
    endcase
  end

  assign drop = push & fifo_full & ~rec.rec_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cycle_q     <= '0;
      start_q     <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      ivl_q       <= '0;
      lat_q       <= '0;
      iter_q      <= '0;
      stall_q     <= '0;
      txn_q       <= '0;
      drop_q      <= '0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_q + CNT_W'(1);
      start_q     <= start_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      ivl_q       <= ivl_d;
      lat_q       <= lat_d;
      iter_q      <= iter_d;
      stall_q     <= stall_d;
      if (push) txn_q <= txn_q + TXN_ID_W'(1);
      if (drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
      drained_q   <= (state_q == STOPPED) && fifo_empty;
    end
  end

  perf_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rec_d),
    .pop       (rec.rec_ready),
    .pop_data  (rec.rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec.rec_valid = ~fifo_empty;
  assign busy          = (state_q == RUN);
  assign drop_count    = drop_q;
  assign drained       = drained_q;

endmodule

// File: tb/tb_ap_ctrl_perf_sampler.sv
// Directed-plus-random bench for ap_ctrl_perf_sampler against a transaction-level model.
module tb_ap_ctrl_perf_sampler;
  import ap_perf_pkg::*;

  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              ap_start, ap_done, iter_fire, iter_stall, finish;
  logic              busy, drained;
  logic [DROP_W-1:0] drop_count;

  ap_ctrl_perf_sampler_if #(.REC_W(rec_width(CNT_W_DEF, ITER_W_DEF))) rec_if ();

  ap_ctrl_perf_sampler #(
    .CNT_W      (CNT_W_DEF),
    .ITER_W     (ITER_W_DEF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .iter_fire  (iter_fire),
    .iter_stall (iter_stall),
    .finish     (finish),
    .rec        (rec_if),
    .busy       (busy),
    .drop_count (drop_count),
    .drained    (drained)
  );

  always #5 clock = ~clock;

  // Time base: cycle index counted from the first cycle after reset release.
  int unsigned cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int          total = 0;
  int          bad   = 0;
  perf_rec_t   mq[$];
  int unsigned m_txn, m_drop, prev_s;
  bit          have_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_front(input string tag);
    perf_rec_t got, exp;
    got = rec_if.rec_data;
    exp = mq[0];
    chk({tag, ".valid"}, 64'(rec_if.rec_valid), 64'd1);
    chk({tag, ".trunc"}, 64'(got.truncated), 64'(exp.truncated));
    chk({tag, ".txn"}, 64'(got.txn_id), 64'(exp.txn_id));
    chk({tag, ".start"}, 64'(got.start_time), 64'(exp.start_time));
    chk({tag, ".lat"}, 64'(got.latency), 64'(exp.latency));
    chk({tag, ".ivl"}, 64'(got.interval), 64'(exp.interval));
    chk({tag, ".iter"}, 64'(got.iter_count), 64'(exp.iter_count));
    chk({tag, ".stall"}, 64'(got.stall_count), 64'(exp.stall_count));
  endtask

  task automatic model_txn(input bit trunc, input int unsigned s, input int unsigned lat,
                           input int unsigned nf, input int unsigned ns);
    perf_rec_t r;
    r.truncated   = trunc;
    r.txn_id      = 16'(m_txn);
    r.start_time  = s;
    r.latency     = lat;
    r.interval    = have_prev ? s - prev_s : 32'd0;
    r.iter_count  = 16'(nf);
    r.stall_count = ns;
    m_txn++;
    if (mq.size() < DEPTH) mq.push_back(r);
    else if (m_drop < 65535) m_drop++;
    prev_s    = s;
    have_prev = 1'b1;
  endtask

  task automatic clear_inputs();
    ap_start   = 1'b0;
    ap_done    = 1'b0;
    iter_fire  = 1'b0;
    iter_stall = 1'b0;
    finish     = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    clear_inputs();
    rec_if.rec_ready = 1'b0;
    #1;
    chk({tag, ".valid"}, 64'(rec_if.rec_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".drop"}, 64'(drop_count), 64'd0);
    chk({tag, ".drained"}, 64'(drained), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    mq.delete();
    m_txn     = 0;
    m_drop    = 0;
    prev_s    = 0;
    have_prev = 1'b0;
  endtask

  // Idle cycles with noise on inputs the sampler must ignore outside a transaction.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ap_start   = 1'b0;
      ap_done    = 1'($urandom_range(0, 1));
      iter_fire  = 1'($urandom_range(0, 1));
      iter_stall = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    clear_inputs();
  endtask

  // Start now, end (done or finish) len cycles later; called and returns at a negedge.
  task automatic run_txn(input int len, input bit trunc, input int fire_n, input int stall_n,
                         input bit rnd);
    int unsigned s, nf, ns;
    bit          f, st;
    s  = cyc;
    nf = 0;
    ns = 0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) @(negedge clock);
      if (k == 1) chk("busy_run", 64'(busy), 64'd1);
      if (rnd) begin
        f  = 1'($urandom_range(0, 1));
        st = 1'($urandom_range(0, 1));
      end else begin
        f  = (k >= 1 && k <= fire_n);
        st = (k > fire_n && k <= fire_n + stall_n);
      end
      ap_start   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ap_done    = (k == len) && !trunc;
      finish     = (k == len) && trunc;
      iter_fire  = f;
      iter_stall = st;
      nf += 32'(f);
      ns += 32'(st);
    end
    @(negedge clock);
    clear_inputs();
    model_txn(trunc, s, len, nf, ns);
    chk("valid_after_push", 64'(rec_if.rec_valid), 64'(mq.size() != 0));
    chk("busy_after", 64'(busy), 64'd0);
    chk("drop", 64'(drop_count), 64'(m_drop));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_front("drain");
      rec_if.rec_ready = 1'b1;
      void'(mq.pop_front());
    end
    @(negedge clock);
    rec_if.rec_ready = 1'b0;
  endtask

  initial begin
    int unsigned s;
    bit          f, st;
    reset = 1'b0;
    clear_inputs();
    rec_if.rec_ready = 1'b0;
    #1;
    do_reset("rst0");

    // Basic transaction then back-to-back start two cycles after done.
    idle(10);
    run_txn(15, 1'b0, 8, 3, 1'b0);
    idle(1);
    run_txn(3, 1'b0, 0, 0, 1'b1);
    drain(2);

    // Start and done in the same idle cycle.
    idle(2);
    run_txn(0, 1'b0, 0, 0, 1'b1);
    drain(1);

    // Backpressure: six transactions into a four-deep FIFO.
    do_reset("rst1");
    for (int i = 0; i < 6; i++) begin
      idle(1);
      run_txn(int'($urandom_range(1, 4)), 1'b0, 0, 0, 1'b1);
    end
    chk("drop_bp", 64'(drop_count), 64'd2);
    idle(3);
    check_front("bp_hold");

    // Pop and push in the same cycle while full: push must not be dropped.
    @(negedge clock);
    check_front("pp");
    s  = cyc;
    f  = 1'($urandom_range(0, 1));
    st = 1'($urandom_range(0, 1));
    ap_start = 1'b1;
    ap_done  = 1'b1;
    iter_fire  = f;
    iter_stall = st;
    rec_if.rec_ready = 1'b1;
    void'(mq.pop_front());
    @(negedge clock);
    clear_inputs();
    rec_if.rec_ready = 1'b0;
    model_txn(1'b0, s, 0, 32'(f), 32'(st));
    chk("pp_drop", 64'(drop_count), 64'd2);
    drain(4);

    // Randomized transactions with occasional drains.
    do_reset("rst2");
    for (int i = 0; i < 25; i++) begin
      idle(int'($urandom_range(0, 3)));
      run_txn(int'($urandom_range(0, 10)), 1'b0, 0, 0, 1'b1);
      if ($urandom_range(0, 2) == 0) drain(mq.size());
    end
    drain(mq.size());

    // Finish mid-run: truncated record, then terminal.
    do_reset("rst3");
    idle(3);
    run_txn(7, 1'b1, 0, 0, 1'b1);
    chk("drained_pre", 64'(drained), 64'd0);
    drain(1);
    @(negedge clock);
    @(negedge clock);
    chk("drained", 64'(drained), 64'd1);
    ap_start = 1'b1;
    ap_done  = 1'b1;
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    chk("stopped_valid", 64'(rec_if.rec_valid), 64'd0);
    chk("stopped_busy", 64'(busy), 64'd0);
    chk("stopped_drained", 64'(drained), 64'd1);

    // Finish beats ap_start in IDLE.
    do_reset("rst4");
    idle(2);
    ap_start = 1'b1;
    finish   = 1'b1;
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    chk("fin_idle_valid", 64'(rec_if.rec_valid), 64'd0);
    chk("fin_idle_busy", 64'(busy), 64'd0);
    chk("fin_idle_drained", 64'(drained), 64'd1);

    // Asynchronous reset in the middle of a run with records queued and drops counted.
    do_reset("rst5");
    for (int i = 0; i < 6; i++) run_txn(0, 1'b0, 0, 0, 1'b1);
    ap_start = 1'b1;
    @(negedge clock);
    ap_start = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_valid", 64'(rec_if.rec_valid), 64'd1);
    #2;
    do_reset("async_rst");
    @(negedge clock);
    chk("post_rst_valid", 64'(rec_if.rec_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
